// File: rtl/counter_bcd_conv.sv
// counter_bcd_conv: sequential double-dabble binary-to-BCD converter with START/BUSY/DONE handshake
module counter_bcd_conv #(
  parameter int IN_WIDTH = 10,
  parameter int DIGITS = 4
) (
  input logic CLOCK,
  input logic RESET,
  input logic START,
  input logic [IN_WIDTH-1:0] BIN_IN,
  output logic BUSY,
  output logic DONE,
  output logic [4*DIGITS-1:0] BCD_OUT
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  function automatic bit fits();
    longint p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    return p > (longint'(1) << IN_WIDTH) - 1;
  endfunction
  if (!fits()) begin : g_chk
    $error("10**DIGITS must exceed 2**IN_WIDTH-1");
  end
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, nxt;
  logic [IN_WIDTH-1:0] sh;
  logic [BW-1:0] scratch, adj, next_scratch;
  logic [CW-1:0] cnt;
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = scratch[4*i+:4] + (scratch[4*i+:4] >= 4'd5 ? 4'd3 : 4'd0);
    next_scratch = {adj[BW-2:0], sh[IN_WIDTH-1]};
    nxt = state == IDLE ? (START ? SHIFT : IDLE) : (cnt == CW'(1) ? IDLE : SHIFT);
  end
  assign BUSY = state == SHIFT;
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      DONE <= 1'b0;
      BCD_OUT <= '0;
      sh <= '0;
      scratch <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      DONE <= state == SHIFT && cnt == CW'(1);
      if (state == IDLE && START) begin
        sh <= BIN_IN;
        scratch <= '0;
        cnt <= CW'(IN_WIDTH);
      end else if (state == SHIFT) begin
        sh <= sh << 1;
        scratch <= next_scratch;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) BCD_OUT <= next_scratch;
      end
    end
  end
endmodule
